// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a built-in L1 D-cache access controller.
// State changes on the falling clock edge. A load or store holds the pipe until the cache answers.
module ex_mem_stage #(
   parameter int PC_SIZE   = 32,
   parameter int DATA_SIZE = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 stall_in_i,
   input  logic                 flush_i,
   input  logic                 EX_MemtoReg_i,
   input  logic                 EX_RegWrite_i,
   input  logic                 EX_MemRead_i,
   input  logic                 EX_MemWrite_i,
   input  logic                 EX_JalCtrl_i,
   input  logic                 EX_LhCtrl_i,
   input  logic                 EX_ShCtrl_i,
   input  logic [PC_SIZE-1:0]   EX_PC_i,
   input  logic [DATA_SIZE-1:0] EX_ALU_result_i,
   input  logic [DATA_SIZE-1:0] EX_Rt_data_i,
   input  logic [4:0]           EX_WR_out_i,
   input  logic                 dc_ready_i,
   input  logic [DATA_SIZE-1:0] dc_rdata_i,
   output logic                 MEM_MemtoReg_o,
   output logic                 MEM_RegWrite_o,
   output logic                 MEM_MemRead_o,
   output logic                 MEM_MemWrite_o,
   output logic                 MEM_JalCtrl_o,
   output logic                 MEM_LhCtrl_o,
   output logic                 MEM_ShCtrl_o,
   output logic [PC_SIZE-1:0]   MEM_PC_o,
   output logic [DATA_SIZE-1:0] MEM_ALU_result_o,
   output logic [4:0]           MEM_WR_out_o,
   output logic [DATA_SIZE-1:0] MEM_load_data_o,
   output logic                 dc_req_o,
   output logic                 dc_we_o,
   output logic [DATA_SIZE-1:0] dc_addr_o,
   output logic [DATA_SIZE-1:0] dc_wdata_o,
   output logic [3:0]           dc_be_o,
   output logic                 mem_stall_o
);

   typedef enum logic {IDLE, ACCESS} state_e;

   typedef struct packed {
      logic                 memtoReg;
      logic                 regWrite;
      logic                 memRead;
      logic                 memWrite;
      logic                 jal;
      logic                 lh;
      logic                 sh;
      logic [PC_SIZE-1:0]   pc;
      logic [DATA_SIZE-1:0] alu;
      logic [DATA_SIZE-1:0] rt;
      logic [4:0]           wr;
   } stage_t;

   state_e               state_q, state_d;
   stage_t               stage_q, stage_d, exIn;
   logic [DATA_SIZE-1:0] loadData_q, loadData_d;
   logic [DATA_SIZE-1:0] loadFmt;
   logic [15:0]          rdHalf;
   logic                 isLoad, isStore;

   assign exIn = '{memtoReg: EX_MemtoReg_i, regWrite: EX_RegWrite_i,
                   memRead:  EX_MemRead_i,  memWrite: EX_MemWrite_i,
                   jal:      EX_JalCtrl_i,  lh:       EX_LhCtrl_i,
                   sh:       EX_ShCtrl_i,   pc:       EX_PC_i,
                   alu:      EX_ALU_result_i, rt:     EX_Rt_data_i,
                   wr:       EX_WR_out_i};

   // A request with both read and write set behaves as a store.
   assign isStore = stage_q.memWrite;
   assign isLoad  = stage_q.memRead & ~stage_q.memWrite;
   assign rdHalf  = stage_q.alu[1] ? dc_rdata_i[31:16] : dc_rdata_i[15:0];
   assign loadFmt = stage_q.lh ? {{(DATA_SIZE-16){rdHalf[15]}}, rdHalf} : dc_rdata_i;

   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         stage_q    <= '0;
         loadData_q <= '0;
      end else begin
         state_q    <= state_d;
         stage_q    <= stage_d;
         loadData_q <= loadData_d;
      end
   end

   // ACCESS freezes the register; the EX instruction waiting behind it loads only once back in IDLE.
   always_comb begin
      state_d    = state_q;
      stage_d    = stage_q;
      loadData_d = loadData_q;
      case (state_q)
         ACCESS: begin
            if (dc_ready_i) begin
               state_d = IDLE;
               if (isLoad) loadData_d = loadFmt;
            end
         end
         default: begin
            if (!stall_in_i) begin
               if (flush_i) begin
                  stage_d    = '0;
                  loadData_d = '0;
               end else begin
                  stage_d = exIn;
                  if (EX_MemRead_i | EX_MemWrite_i) state_d = ACCESS;
               end
            end
         end
      endcase
   end

   always_comb begin
      dc_wdata_o = '0;
      dc_be_o    = 4'b0000;
      if (state_q == ACCESS) begin
         dc_be_o = 4'b1111;
         if (isStore) begin
            dc_wdata_o = stage_q.rt;
            if (stage_q.sh) begin
               dc_wdata_o = {(DATA_SIZE/16){stage_q.rt[15:0]}};
               dc_be_o    = stage_q.alu[1] ? 4'b1100 : 4'b0011;
            end
         end
      end
   end

   assign dc_req_o         = (state_q == ACCESS);
   assign mem_stall_o      = (state_q == ACCESS);
   assign dc_we_o          = stage_q.memWrite;
   assign dc_addr_o        = {stage_q.alu[DATA_SIZE-1:2], 2'b00};

   assign MEM_MemtoReg_o   = stage_q.memtoReg;
   assign MEM_RegWrite_o   = stage_q.regWrite;
   assign MEM_MemRead_o    = stage_q.memRead;
   assign MEM_MemWrite_o   = stage_q.memWrite;
   assign MEM_JalCtrl_o    = stage_q.jal;
   assign MEM_LhCtrl_o     = stage_q.lh;
   assign MEM_ShCtrl_o     = stage_q.sh;
   assign MEM_PC_o         = stage_q.pc;
   assign MEM_ALU_result_o = stage_q.alu;
   assign MEM_WR_out_o     = stage_q.wr;
   assign MEM_load_data_o  = loadData_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed cache scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the pipe register and cache handshake.
module tb_ex_mem_stage;

   typedef struct packed {
      logic        memtoReg;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
      logic        jal;
      logic        lh;
      logic        sh;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] rt;
      logic [4:0]  wr;
   } instr_t;

   logic        clk = 1'b0;
   logic        rstN = 1'b1;
   logic        stallIn, flush, dcReady;
   logic [31:0] dcRdata;
   instr_t      ex;

   logic        memMemtoReg, memRegWrite, memMemRead, memMemWrite, memJal, memLh, memSh;
   logic [31:0] memPc, memAlu, memLoadData, dcAddr, dcWdata;
   logic [4:0]  memWr;
   logic        dcReq, dcWe, memStall;
   logic [3:0]  dcBe;

   instr_t      mMem;
   logic        mBusy;
   logic [31:0] mLoad;

   int checks = 0;
   int failures = 0;
   int stallCycles = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(.PC_SIZE(32), .DATA_SIZE(32)) dut (
      .clk_i(clk), .rst_ni(rstN), .stall_in_i(stallIn), .flush_i(flush),
      .EX_MemtoReg_i(ex.memtoReg), .EX_RegWrite_i(ex.regWrite),
      .EX_MemRead_i(ex.memRead), .EX_MemWrite_i(ex.memWrite),
      .EX_JalCtrl_i(ex.jal), .EX_LhCtrl_i(ex.lh), .EX_ShCtrl_i(ex.sh),
      .EX_PC_i(ex.pc), .EX_ALU_result_i(ex.alu), .EX_Rt_data_i(ex.rt),
      .EX_WR_out_i(ex.wr), .dc_ready_i(dcReady), .dc_rdata_i(dcRdata),
      .MEM_MemtoReg_o(memMemtoReg), .MEM_RegWrite_o(memRegWrite),
      .MEM_MemRead_o(memMemRead), .MEM_MemWrite_o(memMemWrite),
      .MEM_JalCtrl_o(memJal), .MEM_LhCtrl_o(memLh), .MEM_ShCtrl_o(memSh),
      .MEM_PC_o(memPc), .MEM_ALU_result_o(memAlu), .MEM_WR_out_o(memWr),
      .MEM_load_data_o(memLoadData), .dc_req_o(dcReq), .dc_we_o(dcWe),
      .dc_addr_o(dcAddr), .dc_wdata_o(dcWdata), .dc_be_o(dcBe),
      .mem_stall_o(memStall)
   );

   // Load result as the memory system defines it: whole word, or the addressed halfword sign-extended.
   function automatic logic [31:0] fmtLoad(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic isHalf);
      int h;
      if (!isHalf) return rdata;
      h = int'((rdata >> (16 * addr[1])) & 32'hFFFF);
      if (h >= 32768) h = h - 65536;
      return 32'(h);
   endfunction

   // Reference: one instruction held in MEM, a busy flag while the cache owes an answer.
   always @(negedge clk or negedge rstN) begin
      if (!rstN) begin
         mMem  <= '0;
         mBusy <= 1'b0;
         mLoad <= '0;
      end else if (mBusy) begin
         if (dcReady) begin
            mBusy <= 1'b0;
            if (mMem.memRead && !mMem.memWrite) mLoad <= fmtLoad(dcRdata, mMem.alu, mMem.lh);
         end
      end else if (!stallIn) begin
         if (flush) begin
            mMem  <= '0;
            mLoad <= '0;
         end else begin
            mMem  <= ex;
            mBusy <= ex.memRead || ex.memWrite;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compareAll();
      logic [31:0] expBe, expWdata;
      expBe    = 32'h0;
      expWdata = 32'h0;
      if (mBusy) begin
         expBe = 32'hF;
         if (mMem.memWrite) begin
            expWdata = mMem.rt;
            if (mMem.sh) begin
               expBe    = 32'h3 << (2 * mMem.alu[1]);
               expWdata = (mMem.rt & 32'hFFFF) * 32'h0001_0001;
            end
         end
      end
      checkOutput("dc_req", 32'(dcReq), 32'(mBusy));
      checkOutput("mem_stall", 32'(memStall), 32'(mBusy));
      checkOutput("dc_we", 32'(dcWe), 32'(mMem.memWrite));
      checkOutput("dc_addr", dcAddr, mMem.alu & ~32'h3);
      checkOutput("dc_be", 32'(dcBe), expBe);
      checkOutput("dc_wdata", dcWdata, expWdata);
      checkOutput("MEM_MemtoReg", 32'(memMemtoReg), 32'(mMem.memtoReg));
      checkOutput("MEM_RegWrite", 32'(memRegWrite), 32'(mMem.regWrite));
      checkOutput("MEM_MemRead", 32'(memMemRead), 32'(mMem.memRead));
      checkOutput("MEM_MemWrite", 32'(memMemWrite), 32'(mMem.memWrite));
      checkOutput("MEM_JalCtrl", 32'(memJal), 32'(mMem.jal));
      checkOutput("MEM_LhCtrl", 32'(memLh), 32'(mMem.lh));
      checkOutput("MEM_ShCtrl", 32'(memSh), 32'(mMem.sh));
      checkOutput("MEM_PC", memPc, mMem.pc);
      checkOutput("MEM_ALU_result", memAlu, mMem.alu);
      checkOutput("MEM_WR_out", 32'(memWr), 32'(mMem.wr));
      checkOutput("MEM_load_data", memLoadData, mLoad);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      compareAll();
      if (memStall) stallCycles++;
      #1;
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic half,
                                input logic [31:0] alu, input logic [31:0] rt);
      ex.memtoReg = rd;
      ex.regWrite = rd;
      ex.memRead  = rd;
      ex.memWrite = wr;
      ex.jal      = 1'b0;
      ex.lh       = half & rd;
      ex.sh       = half & wr;
      ex.pc       = 32'h400 + alu;
      ex.alu      = alu;
      ex.rt       = rt;
      ex.wr       = 5'd8;
   endtask

   initial begin
      ex      = '0;
      stallIn = 1'b0;
      flush   = 1'b0;
      dcReady = 1'b0;
      dcRdata = 32'h0;
      #1 rstN = 1'b0;
      nextCycle();
      nextCycle();
      checkOutput("reset_req", 32'(dcReq), 32'h0);
      checkOutput("reset_alu", memAlu, 32'h0);
      checkOutput("reset_load", memLoadData, 32'h0);
      rstN = 1'b1;
      nextCycle();

      $display("[TB] lw with immediate ready");
      stallCycles = 0;
      applyStimulus(1, 0, 0, 32'h100, 32'h0);
      dcReady = 1'b1;
      dcRdata = 32'hDEADBEEF;
      nextCycle();
      checkOutput("t1_req", 32'(dcReq), 32'h1);
      checkOutput("t1_addr", dcAddr, 32'h100);
      applyStimulus(0, 0, 0, 32'h40, 32'h0);
      nextCycle();
      checkOutput("t1_stall_end", 32'(memStall), 32'h0);
      checkOutput("t1_load", memLoadData, 32'hDEADBEEF);
      checkOutput("t1_stall_cycles", 32'(stallCycles), 32'h1);

      $display("[TB] lw with three wait cycles");
      nextCycle();
      stallCycles = 0;
      applyStimulus(1, 0, 0, 32'h204, 32'h0);
      dcReady = 1'b0;
      dcRdata = 32'h11112222;
      nextCycle();
      applyStimulus(0, 0, 0, 32'h55, 32'h0);
      nextCycle();
      nextCycle();
      checkOutput("t2_addr_stable", dcAddr, 32'h204);
      nextCycle();
      checkOutput("t2_alu_frozen", memAlu, 32'h204);
      dcReady = 1'b1;
      nextCycle();
      checkOutput("t2_stall_cycles", 32'(stallCycles), 32'h4);
      checkOutput("t2_not_loaded_yet", memAlu, 32'h204);
      checkOutput("t2_load", memLoadData, 32'h11112222);
      nextCycle();
      checkOutput("t2_next_loaded", memAlu, 32'h55);

      $display("[TB] sh formatting");
      applyStimulus(0, 1, 1, 32'h102, 32'h1234ABCD);
      dcReady = 1'b0;
      nextCycle();
      checkOutput("t3_we", 32'(dcWe), 32'h1);
      checkOutput("t3_be_hi", 32'(dcBe), 32'hC);
      checkOutput("t3_wdata", dcWdata, 32'hABCDABCD);
      dcReady = 1'b1;
      applyStimulus(0, 1, 1, 32'h100, 32'h1234ABCD);
      nextCycle();
      nextCycle();
      checkOutput("t3_be_lo", 32'(dcBe), 32'h3);
      checkOutput("t3_wdata_lo", dcWdata, 32'hABCDABCD);
      applyStimulus(0, 0, 0, 32'h40, 32'h0);
      nextCycle();

      $display("[TB] lh sign extension");
      dcRdata = 32'h80010002;
      applyStimulus(1, 0, 1, 32'h102, 32'h0);
      nextCycle();
      applyStimulus(1, 0, 1, 32'h100, 32'h0);
      nextCycle();
      checkOutput("t4_lh_hi", memLoadData, 32'hFFFF8001);
      nextCycle();
      applyStimulus(0, 0, 0, 32'h40, 32'h0);
      nextCycle();
      checkOutput("t4_lh_lo", memLoadData, 32'h00000002);

      $display("[TB] external stall and flush");
      applyStimulus(1, 0, 0, 32'h300, 32'h0);
      stallIn = 1'b1;
      nextCycle();
      nextCycle();
      nextCycle();
      checkOutput("t5_no_req", 32'(dcReq), 32'h0);
      checkOutput("t5_held", memAlu, 32'h100);
      stallIn = 1'b0;
      nextCycle();
      checkOutput("t5_req_after", 32'(dcReq), 32'h1);
      checkOutput("t5_addr", dcAddr, 32'h300);
      applyStimulus(0, 0, 0, 32'h40, 32'h0);
      nextCycle();
      applyStimulus(0, 1, 0, 32'h500, 32'h77);
      flush = 1'b1;
      nextCycle();
      checkOutput("t5_flush_req", 32'(dcReq), 32'h0);
      checkOutput("t5_flush_we", 32'(memMemWrite), 32'h0);
      checkOutput("t5_flush_alu", memAlu, 32'h0);
      checkOutput("t5_flush_load", memLoadData, 32'h0);
      flush = 1'b0;
      applyStimulus(0, 0, 0, 32'h40, 32'h0);
      nextCycle();

      $display("[TB] reset during access");
      applyStimulus(1, 0, 0, 32'h600, 32'h0);
      dcReady = 1'b0;
      nextCycle();
      nextCycle();
      rstN = 1'b0;
      #1;
      checkOutput("t6_req", 32'(dcReq), 32'h0);
      checkOutput("t6_stall", 32'(memStall), 32'h0);
      checkOutput("t6_alu", memAlu, 32'h0);
      checkOutput("t6_pc", memPc, 32'h0);
      nextCycle();
      rstN = 1'b1;
      dcReady = 1'b1;
      applyStimulus(1, 0, 0, 32'h700, 32'h0);
      nextCycle();
      checkOutput("t6_req_again", 32'(dcReq), 32'h1);
      checkOutput("t6_addr_again", dcAddr, 32'h700);
      applyStimulus(0, 0, 0, 32'h40, 32'h0);
      nextCycle();

      $display("[TB] randomized traffic");
      for (int i = 0; i < 3000; i++) begin
         ex.memtoReg = 1'($urandom_range(0, 1));
         ex.regWrite = 1'($urandom_range(0, 1));
         ex.memRead  = ($urandom_range(0, 2) == 0);
         ex.memWrite = ($urandom_range(0, 3) == 0);
         ex.jal      = 1'($urandom_range(0, 1));
         ex.lh       = 1'($urandom_range(0, 1));
         ex.sh       = 1'($urandom_range(0, 1));
         ex.pc       = $urandom();
         ex.alu      = $urandom();
         ex.rt       = $urandom();
         ex.wr       = 5'($urandom());
         stallIn     = ($urandom_range(0, 4) == 0);
         flush       = ($urandom_range(0, 5) == 0);
         dcReady     = ($urandom_range(0, 2) == 0);
         dcRdata     = $urandom();
         rstN        = ($urandom_range(0, 299) != 0);
         nextCycle();
      end
      rstN = 1'b1;
      nextCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
